// File: rtl/mypio_pkg.sv
// Shared constants and FSM encoding for the PIO hex poller.
package mypio_pkg;

    localparam logic     ADDR_HEX  = 1'b0;
    localparam logic     ADDR_SW   = 1'b1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CMP  = 2'd2,
        WR   = 2'd3
    } state_t;

endpackage

// File: rtl/mypio_hex_poller_if.sv
// Avalon-MM master/slave bundle between the poller and the PIO slave.
interface mypio_hex_poller_if;

    logic       m_address;
    logic       m_read;
    logic       m_write;
    logic [7:0] m_writedata;
    logic [7:0] m_readdata;
    logic       m_waitrequest;

    modport master (
        output m_address, m_read, m_write, m_writedata,
        input  m_readdata, m_waitrequest
    );

    modport slave (
        input  m_address, m_read, m_write, m_writedata,
        output m_readdata, m_waitrequest
    );

endinterface

// File: rtl/mypio_hex_poller_seg7_decode.sv
// Hex nibble to active-low 7-segment pattern (bit0 = a .. bit6 = g).
module seg7_decode
    import mypio_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mypio_hex_poller.sv
// Periodically reads the PIO switch register and mirrors the nibble onto the
// 7-segment register, writing only on change or on the first poll after reset.
module mypio_hex_poller
    import mypio_pkg::*;
#(
    parameter int PERIOD = 50000,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    mypio_hex_poller_if.master  bus,
    output logic [3:0]          sw_value,
    output logic                update,
    output logic                busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             start;
    state_t           state;
    logic             first;
    logic             changed;
    logic [6:0]       seg;
    logic             unused_rd_hi;

    assign unused_rd_hi = &{1'b0, bus.m_readdata[7:4]};

    // Free-running poll timer; it keeps counting through transactions so the
    // poll rate does not drift, and a start landing while busy is simply lost.
    assign start = enable && (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= RELOAD;
        end else if (enable) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
        end
    end

    seg7_decode u_dec (
        .nibble (sw_value),
        .seg    (seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            bus.m_read      <= 1'b0;
            bus.m_write     <= 1'b0;
            bus.m_address   <= ADDR_HEX;
            bus.m_writedata <= {1'b0, SEG_BLANK};
            sw_value        <= 4'h0;
            update          <= 1'b0;
            busy            <= 1'b0;
            first           <= 1'b1;
            changed         <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RD;
                        bus.m_read    <= 1'b1;
                        bus.m_address <= ADDR_SW;
                        busy          <= 1'b1;
                    end
                end
                RD: begin
                    if (!bus.m_waitrequest) begin
                        state      <= CMP;
                        bus.m_read <= 1'b0;
                        sw_value   <= bus.m_readdata[3:0];
                        changed    <= (bus.m_readdata[3:0] != sw_value);
                    end
                end
                CMP: begin
                    if (changed || first) begin
                        state           <= WR;
                        bus.m_write     <= 1'b1;
                        bus.m_address   <= ADDR_HEX;
                        bus.m_writedata <= {1'b0, seg};
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WR: begin
                    if (!bus.m_waitrequest) begin
                        state       <= IDLE;
                        bus.m_write <= 1'b0;
                        update      <= 1'b1;
                        first       <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mypio_hex_poller.sv
// Directed bench for mypio_hex_poller with PERIOD=8 and a modelled PIO slave.
module tb_mypio_hex_poller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] sw_in;
    logic       waitreq;
    logic [3:0] sw_value;
    logic       update;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] sw;
        logic       wr;
        logic [7:0] wd;
    } vec_t;

    vec_t vecs [20];

    mypio_hex_poller_if bus ();

    // Zero-latency slave: switches on the low nibble, junk on the high nibble.
    assign bus.m_readdata    = {4'hC, sw_in};
    assign bus.m_waitrequest = waitreq;

    mypio_hex_poller #(.PERIOD(8), .CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .bus      (bus.master),
        .sw_value (sw_value),
        .update   (update),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_read(input int exp_gap, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.m_read && n < 40);
        if (!bus.m_read) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no read want read within 40 cycles", tag);
        end else begin
            check({tag, "_gap"}, 32'(n), 32'(exp_gap));
        end
    endtask

    task automatic do_poll(input logic [3:0] sw, input logic exp_wr, input logic [7:0] wd,
                           input int gap, input string tag);
        sw_in = sw;
        wait_read(gap, tag);
        check({tag, "_rd_addr"}, 32'(bus.m_address), 32'(1));
        check({tag, "_rd_nowr"}, 32'(bus.m_write), 32'(0));
        step();
        check({tag, "_cmp_rd"}, 32'(bus.m_read), 32'(0));
        check({tag, "_sw_value"}, 32'(sw_value), 32'(sw));
        check({tag, "_cmp_busy"}, 32'(busy), 32'(1));
        step();
        check({tag, "_wr"}, 32'(bus.m_write), 32'(exp_wr));
        if (exp_wr) begin
            check({tag, "_wr_addr"}, 32'(bus.m_address), 32'(0));
            check({tag, "_wdata"}, 32'(bus.m_writedata), 32'(wd));
        end else begin
            check({tag, "_idle_busy"}, 32'(busy), 32'(0));
        end
        step();
        check({tag, "_update"}, 32'(update), 32'(exp_wr));
        check({tag, "_end_wr"}, 32'(bus.m_write), 32'(0));
        check({tag, "_end_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        vecs[0]  = '{4'h3, 1'b1, 8'h30};
        vecs[1]  = '{4'h3, 1'b0, 8'h00};
        vecs[2]  = '{4'h3, 1'b0, 8'h00};
        vecs[3]  = '{4'h3, 1'b0, 8'h00};
        vecs[4]  = '{4'hA, 1'b1, 8'h08};
        vecs[5]  = '{4'h0, 1'b1, 8'h40};
        vecs[6]  = '{4'h1, 1'b1, 8'h79};
        vecs[7]  = '{4'h2, 1'b1, 8'h24};
        vecs[8]  = '{4'h4, 1'b1, 8'h19};
        vecs[9]  = '{4'h5, 1'b1, 8'h12};
        vecs[10] = '{4'h6, 1'b1, 8'h02};
        vecs[11] = '{4'h7, 1'b1, 8'h78};
        vecs[12] = '{4'h8, 1'b1, 8'h00};
        vecs[13] = '{4'h9, 1'b1, 8'h10};
        vecs[14] = '{4'hB, 1'b1, 8'h03};
        vecs[15] = '{4'hC, 1'b1, 8'h46};
        vecs[16] = '{4'hD, 1'b1, 8'h21};
        vecs[17] = '{4'hE, 1'b1, 8'h06};
        vecs[18] = '{4'hF, 1'b1, 8'h0E};
        vecs[19] = '{4'hF, 1'b0, 8'h00};

        reset_n = 1'b0;
        enable  = 1'b1;
        sw_in   = 4'h3;
        waitreq = 1'b0;
        step();
        step();
        check("rst_read",  32'(bus.m_read),      32'(0));
        check("rst_write", 32'(bus.m_write),     32'(0));
        check("rst_addr",  32'(bus.m_address),   32'(0));
        check("rst_wdata", 32'(bus.m_writedata), 32'h7F);
        check("rst_sw",    32'(sw_value),        32'(0));
        check("rst_upd",   32'(update),          32'(0));
        check("rst_busy",  32'(busy),            32'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            do_poll(vecs[i].sw, vecs[i].wr, vecs[i].wd, (i == 0) ? 8 : 5,
                    $sformatf("vec%0d", i));
        end

        // Stalled read then stalled write; the start falling inside it is dropped.
        sw_in   = 4'h5;
        waitreq = 1'b1;
        wait_read(5, "stall");
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) sw_in = 4'h6;
            step();
            check("stall_rd",      32'(bus.m_read),    32'(1));
            check("stall_rd_addr", 32'(bus.m_address), 32'(1));
            check("stall_rd_sw",   32'(sw_value),      32'hF);
        end
        waitreq = 1'b0;
        step();
        check("stall_cap_sw", 32'(sw_value),   32'h6);
        check("stall_cap_rd", 32'(bus.m_read), 32'(0));
        waitreq = 1'b1;
        step();
        check("stall_wr_go", 32'(bus.m_write), 32'(1));
        for (int i = 7; i <= 10; i++) begin
            step();
            check("stall_wr",      32'(bus.m_write),     32'(1));
            check("stall_wr_addr", 32'(bus.m_address),   32'(0));
            check("stall_wr_data", 32'(bus.m_writedata), 32'h02);
            check("stall_wr_upd",  32'(update),          32'(0));
        end
        waitreq = 1'b0;
        step();
        check("stall_upd",    32'(update),      32'(1));
        check("stall_wr_end", 32'(bus.m_write), 32'(0));

        // Disable during the write: it finishes, then the counter freezes.
        sw_in = 4'h9;
        wait_read(5, "dis");
        step();
        step();
        check("dis_wr",    32'(bus.m_write),     32'(1));
        check("dis_wdata", 32'(bus.m_writedata), 32'h10);
        enable = 1'b0;
        step();
        check("dis_upd",  32'(update), 32'(1));
        check("dis_busy", 32'(busy),   32'(0));
        for (int i = 0; i < 10; i++) begin
            step();
            check("dis_no_rd", 32'(bus.m_read), 32'(0));
        end
        enable = 1'b1;
        wait_read(6, "reen");

        // Reset in the middle of a read; first poll afterwards must write.
        sw_in   = 4'h0;
        reset_n = 1'b0;
        #1;
        check("rst_mid_rd",   32'(bus.m_read), 32'(0));
        check("rst_mid_busy", 32'(busy),       32'(0));
        check("rst_mid_sw",   32'(sw_value),   32'(0));
        step();
        reset_n = 1'b1;
        do_poll(4'h0, 1'b1, 8'h40, 8, "post_rst");
        do_poll(4'h0, 1'b0, 8'h00, 5, "post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
